wid_width_packer: RTL
=====================

WID_WIDTH_PACKER -- requirements
Module: wid_width_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input beat width in bits, legal range >=1.
REQ-002 SHALL have parameter MULTIPLIER, default 2: lanes per output word; a value <2 SHALL cause an elaboration error.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port mode, input, 1: 0 = PACK (accumulate beats), 1 = REPLICATE (one beat fills all lanes).
REQ-006 SHALL have port in_valid, input, 1: input beat valid.
REQ-007 SHALL have port in_ready, output, 1: input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WIDTH: input beat.
REQ-009 SHALL have port in_last, input, 1: final beat of a packet; forces emission of a partial word.
REQ-010 SHALL have port out_valid, output, 1: output word valid.
REQ-011 SHALL have port out_ready, input, 1: output word consumed when out_valid && out_ready.
REQ-012 SHALL have port out_data, output, WIDTH*MULTIPLIER: packed or replicated word.
REQ-013 SHALL have port out_keep, output, MULTIPLIER: bit i = 1 when lane i holds a valid beat.

Function
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL run an accumulator FSM with states IDLE (lane count 0) and FILL (lane count 1..MULTIPLIER-1).
REQ-016 SHALL sample mode only on a beat accepted in IDLE; a mode change during FILL SHALL be ignored until the word completes.
REQ-017 PACK: SHALL write accepted beat n into lane n and increment the count. The word completes when the count reaches MULTIPLIER or in_last is high. On completion, the count SHALL return to 0 and the FSM to IDLE.
REQ-018 REPLICATE: SHALL complete the word on every accepted beat, with all lanes equal to in_data and out_keep all ones; in_last has no additional effect.
REQ-019 SHALL load out_data/out_keep and assert out_valid on the clock edge that accepts the completing beat (latency 1 cycle from that beat to out_valid).
REQ-020 SHALL zero unfilled lanes and clear their out_keep bits on a partial (in_last) word.
REQ-021 SHALL hold out_data/out_keep stable while out_valid && !out_ready.
REQ-022 SHALL deassert out_valid after a consume cycle unless the same cycle also completes a new word; in that case the new word SHALL be loaded with out_valid kept high (back-to-back, no bubble).
REQ-023 SHALL sustain one beat per cycle in PACK and one word per cycle in REPLICATE while out_ready = 1.
REQ-024 SHALL treat in_last on a beat that also fills lane MULTIPLIER-1 as a single full word (out_keep all ones), not as two words.

Reset
REQ-025 SHALL, while rst_n = 0, force out_valid = 0, out_data = 0, out_keep = 0, lane count = 0 and FSM = IDLE, irrespective of clk.
REQ-026 SHALL discard any partial word and any unconsumed output word on reset asserted mid-operation; no residue SHALL appear after release.
REQ-027 SHALL keep in_ready = 1 during and immediately after reset (out_valid = 0).

Configuration
REQ-028 SHALL support macro WID_PACKER_MSB_FIRST_EN. When defined, beat n SHALL map to lane MULTIPLIER-1-n, occupying bits [(MULTIPLIER-n)*WIDTH-1 -: WIDTH], and out_keep SHALL be mirrored to match. When undefined, beat n SHALL map to lane n (LSB first). REPLICATE output is identical either way.

Structure
REQ-029 SHALL take from shared package wid_pkg: typedef wid_mode_e (WID_MODE_PACK = 0, WID_MODE_REPL = 1) and typedef wid_acc_state_e (IDLE, FILL).
REQ-030 SHALL implement the lane counter as sub-module wid_lane_ctr (parameter MULTIPLIER; inputs inc and clr; outputs count and at_max). The counter width SHALL be $clog2(MULTIPLIER).

Verification (WIDTH=8, MULTIPLIER=4, LSB first unless stated)
REQ-031 PACK, beats 11,22,33,44, out_ready=1 -> out_data=0x44332211, out_keep=4'b1111, out_valid high 1 cycle after beat 44.
REQ-032 PACK, beats AA,BB with in_last on BB -> out_data=0x0000BBAA, out_keep=4'b0011; next word starts in lane 0.
REQ-033 REPLICATE, beat 5A then 3C back-to-back, out_ready=1 -> words 0x5A5A5A5A then 0x3C3C3C3C in consecutive cycles, keep=4'b1111.
REQ-034 PACK, out_ready=0 with word pending -> in_ready=0 and out_data held 10 cycles; on out_ready=1, a new completing beat is loaded in the same cycle.
REQ-035 rst_n pulsed low after beats 01,02 -> out_valid=0; beats 03,04,05,06 -> 0x06050403.
REQ-036 With WID_PACKER_MSB_FIRST_EN, beats 11,22,33,44 -> 0x11223344; partial 11 with in_last -> 0x11000000, keep=4'b1000.

Source files
------------

// File: rtl/wid_pkg.sv
// Shared types for the width packer: accumulation mode and accumulator FSM state.
package wid_pkg;

    typedef enum logic {
        WID_MODE_PACK = 1'b0,
        WID_MODE_REPL = 1'b1
    } wid_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } wid_acc_state_e;

endpackage

// File: rtl/wid_lane_ctr.sv
// Lane counter for the width packer: counts filled lanes 0..MULTIPLIER-1.
module wid_lane_ctr #(
    parameter int MULTIPLIER = 2,
    parameter int CW         = $clog2(MULTIPLIER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_max
);

    // clear wins over increment so a completing beat always restarts at lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + 1'b1;
    end

    assign at_max = (count == CW'(MULTIPLIER - 1));

endmodule

// File: rtl/wid_width_packer.sv
// Width packer: packs MULTIPLIER beats of WIDTH bits into one word (PACK) or
// replicates a single beat across all lanes (REPLICATE).
// Optional macro WID_PACKER_MSB_FIRST_EN: beat n lands in lane MULTIPLIER-1-n.
module wid_width_packer
    import wid_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MULTIPLIER = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH*MULTIPLIER-1:0] out_data,
    output logic [MULTIPLIER-1:0]       out_keep
);

    localparam int CW = $clog2(MULTIPLIER);

    if (MULTIPLIER < 2) begin : g_bad_mult
        $error("wid_width_packer: MULTIPLIER must be >= 2");
    end

    wid_acc_state_e                        state;
    wid_mode_e                             mode_q;
    wid_mode_e                             eff_mode;
    logic [MULTIPLIER-1:0][WIDTH-1:0]      acc_data, nxt_data, word_q;
    logic [MULTIPLIER-1:0]                 acc_keep, nxt_keep;
    logic [CW-1:0]                         count, lane;
    logic                                  at_max, accept, complete;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // mode is only honoured at the start of a word; mid-word changes wait
    assign eff_mode = (state == IDLE) ? wid_mode_e'(mode) : mode_q;
    assign complete = accept && (eff_mode == WID_MODE_REPL || at_max || in_last);

`ifdef WID_PACKER_MSB_FIRST_EN
    assign lane = CW'(MULTIPLIER - 1) - count;
`else
    assign lane = count;
`endif

    wid_lane_ctr #(.MULTIPLIER(MULTIPLIER), .CW(CW)) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (accept && eff_mode == WID_MODE_PACK && !complete),
        .clr    (complete),
        .count  (count),
        .at_max (at_max)
    );

    // word as it would look after merging the current beat
    always_comb begin
        nxt_data = acc_data;
        nxt_keep = acc_keep;
        if (eff_mode == WID_MODE_REPL) begin
            for (int i = 0; i < MULTIPLIER; i++) nxt_data[i] = in_data;
            nxt_keep = '1;
        end else begin
            nxt_data[lane] = in_data;
            nxt_keep[lane] = 1'b1;
        end
    end

    // accumulator FSM plus registered output word; accumulator is kept zeroed
    // between words so a partial word leaves unfilled lanes at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= WID_MODE_PACK;
            acc_data  <= '0;
            acc_keep  <= '0;
            word_q    <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept && state == IDLE) mode_q <= wid_mode_e'(mode);
            if (complete) begin
                state     <= IDLE;
                acc_data  <= '0;
                acc_keep  <= '0;
                word_q    <= nxt_data;
                out_keep  <= nxt_keep;
                out_valid <= 1'b1;
            end else begin
                if (accept) begin
                    state    <= FILL;
                    acc_data <= nxt_data;
                    acc_keep <= nxt_keep;
                end
                if (out_ready) out_valid <= 1'b0;
            end
        end
    end

    assign out_data = word_q;

endmodule
